// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder sequencer.
// Holds the FSM state encoding and the WIDTH upper bound.
// No logic; imported by serial_add_ctrl.
package serial_add_pkg;

    localparam int ST_W      = 2;
    localparam int MAX_WIDTH = 64;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, combinational.
// Latency: zero cycles.
// Backpressure: none; pure function of its inputs.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder, LSB first through one full_adder; optional ovf via SERIAL_ADD_OVF_EN.
// Latency: start at edge k -> done in the cycle after edge k+WIDTH, idle after edge k+WIDTH+1.
// Backpressure: none queued; start is ignored while busy, so requesters wait for busy=0.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_add_ctrl: WIDTH out of range");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_shift;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             last;
    logic             fa_s;
    logic             fa_co;
`ifdef SERIAL_ADD_OVF_EN
    logic             c_msb;
`endif

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Written as shift-then-overwrite so WIDTH=1 needs no special case.
    always_comb begin
        sum_shift            = sum_q >> 1;
        sum_shift[WIDTH-1]   = fa_s;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            c_msb  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                        c_msb  <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    sum_q <= sum_shift;
                    carry <= fa_co;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        cout_q <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        // Carry into the MSB, before the MSB add consumes it.
                        c_msb  <= carry;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = c_msb ^ cout_q;
`endif

endmodule
